// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the slotted instruction RAM.
// The optional checksum stage is enabled with INSTR_RAM_LOAD_CHECKSUM_EN.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } load_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SLOT_DEPTH = 128;
  localparam int DEF_NUM_SLOTS  = 8;

  // ISA Nop encoding, returned by fetches from slots with no resident program
  localparam logic [31:0] NOP_WORD = 32'h6C000000;

endpackage

// File: rtl/instr_load_fsm.sv
// Load-stream controller: handshake, word counter, optional checksum and slot-valid strobes.
// Checksum stage (CHECK state) is built only when INSTR_RAM_LOAD_CHECKSUM_EN is defined.
module instr_load_fsm
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_DEPTH = DEF_SLOT_DEPTH,
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  localparam int OFFS_W = $clog2(SLOT_DEPTH),
  localparam int SLOT_W = $clog2(NUM_SLOTS),
  localparam int LEN_W  = OFFS_W + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic [SLOT_W-1:0]        load_slot,
  input  logic [LEN_W-1:0]         load_length,
  input  logic                     load_valid,
  input  logic [DATA_WIDTH-1:0]    load_data,
  output logic                     load_ready,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_error,
  output logic                     wr_en,
  output logic [SLOT_W+OFFS_W-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     valid_set,
  output logic [SLOT_W-1:0]        set_slot,
  output logic                     valid_clr,
  output logic [SLOT_W-1:0]        clr_slot
);

  load_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [OFFS_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] check_total;
  assign check_total = sum_q + load_data;
`endif

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    error_d   = 1'b0;
    valid_clr = 1'b0;
    valid_set = 1'b0;
    accept    = 1'b0;
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_length == '0 || load_length > LEN_W'(SLOT_DEPTH)) begin
            error_d = 1'b1;
          end else begin
            slot_d    = load_slot;
            len_d     = load_length;
            cnt_d     = '0;
            valid_clr = 1'b1;
            state_d   = LOAD;
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
            sum_d     = '0;
`endif
          end
        end
      end
      LOAD: begin
        if (load_valid && ready_q) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 1'b1;
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
          sum_d  = sum_q + load_data;
          if ({1'b0, cnt_q} == len_q - 1'b1) state_d = CHECK;
`else
          if ({1'b0, cnt_q} == len_q - 1'b1) state_d = DONE;
`endif
        end
      end
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
      CHECK: begin
        // the checksum word is consumed here but never written to memory
        if (load_valid && ready_q) begin
          if (check_total == '0) begin
            state_d = DONE;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      DONE: begin
        valid_set = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD) || (state_d == CHECK);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign load_ready = ready_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign wr_en      = accept;
  assign wr_addr    = {slot_q, cnt_q};
  assign wr_data    = load_data;
  assign set_slot   = slot_q;
  assign clr_slot   = load_slot;

endmodule

// File: rtl/instruction_ram_slots.sv
// Slotted instruction RAM: NUM_SLOTS resident programs filled by a load stream, combinational fetch.
// Optional load checksum is enabled with INSTR_RAM_LOAD_CHECKSUM_EN.
module instruction_ram_slots
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_DEPTH = DEF_SLOT_DEPTH,
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(instr_mem_pkg::NOP_WORD),
  localparam int OFFS_W = $clog2(SLOT_DEPTH),
  localparam int SLOT_W = $clog2(NUM_SLOTS),
  localparam int DEPTH  = SLOT_DEPTH * NUM_SLOTS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SLOT_W-1:0]     fetchSlot,
  input  logic [OFFS_W-1:0]     address,
  output logic [DATA_WIDTH-1:0] iRAMOutput,
  input  logic                  loadStart,
  input  logic [SLOT_W-1:0]     loadSlot,
  input  logic [OFFS_W:0]       loadLength,
  input  logic                  loadValid,
  input  logic [DATA_WIDTH-1:0] loadData,
  output logic                  loadReady,
  output logic                  loadBusy,
  output logic                  loadDone,
  output logic                  loadError
);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [NUM_SLOTS-1:0]     slot_valid_q, slot_valid_d;
  logic                     wr_en;
  logic [SLOT_W+OFFS_W-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     valid_set, valid_clr;
  logic [SLOT_W-1:0]        set_slot, clr_slot;
  logic [SLOT_W+OFFS_W-1:0] fetch_idx;

  instr_load_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOT_DEPTH (SLOT_DEPTH),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_load_fsm (
    .clock       (clock),
    .reset       (reset),
    .load_start  (loadStart),
    .load_slot   (loadSlot),
    .load_length (loadLength),
    .load_valid  (loadValid),
    .load_data   (loadData),
    .load_ready  (loadReady),
    .load_busy   (loadBusy),
    .load_done   (loadDone),
    .load_error  (loadError),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .valid_set   (valid_set),
    .set_slot    (set_slot),
    .valid_clr   (valid_clr),
    .clr_slot    (clr_slot)
  );

  // set (DONE) and clear (IDLE accept) come from different states, never together
  always_comb begin
    slot_valid_d = slot_valid_q;
    if (valid_set) slot_valid_d[set_slot] = 1'b1;
    if (valid_clr) slot_valid_d[clr_slot] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) slot_valid_q <= '0;
    else       slot_valid_q <= slot_valid_d;
  end

  // contents survive reset; only the valid bits are cleared
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign fetch_idx  = {fetchSlot, address};
  assign iRAMOutput = slot_valid_q[fetchSlot] ? mem[fetch_idx] : NOP_WORD;

endmodule

// File: tb/tb_instruction_ram_slots.sv
// Scoreboard bench for instruction_ram_slots; checksum cases run when INSTR_RAM_LOAD_CHECKSUM_EN is defined.
module tb_instruction_ram_slots;

  localparam logic [31:0] NOP = 32'h6C000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  fetchSlot = '0;
  logic [6:0]  address = '0;
  logic [31:0] iRAMOutput;
  logic        loadStart = 1'b0;
  logic [2:0]  loadSlot = '0;
  logic [7:0]  loadLength = '0;
  logic        loadValid = 1'b0;
  logic [31:0] loadData = '0;
  logic        loadReady, loadBusy, loadDone, loadError;

  always #5 clock = ~clock;

  instruction_ram_slots dut (
    .clock      (clock),
    .reset      (reset),
    .fetchSlot  (fetchSlot),
    .address    (address),
    .iRAMOutput (iRAMOutput),
    .loadStart  (loadStart),
    .loadSlot   (loadSlot),
    .loadLength (loadLength),
    .loadValid  (loadValid),
    .loadData   (loadData),
    .loadReady  (loadReady),
    .loadBusy   (loadBusy),
    .loadDone   (loadDone),
    .loadError  (loadError)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        busy;
    logic        ready;
  } fetch_exp_t;

  typedef struct {
    string name;
    bit    is_done;
    int    cyc;
  } ev_exp_t;

  fetch_exp_t fetch_q[$];
  ev_exp_t    ev_q[$];
  fetch_exp_t fe;
  ev_exp_t    ee;
  int  asserts = 0;
  int  fails = 0;
  int  cyc = 0;
  int  tmo_events = 0;
  int  tmo_seen = 0;
  bit  chk_req = 1'b0;
  bit  end_req = 1'b0;
  bit  end_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clock) begin
    if (chk_req && fetch_q.size() > 0) begin
      fe = fetch_q.pop_front();
      asserts += 3;
      if (iRAMOutput !== fe.data) begin
        fails++;
        $display("FAIL %s data got %h want %h", fe.name, iRAMOutput, fe.data);
      end
      if (loadBusy !== fe.busy) begin
        fails++;
        $display("FAIL %s busy got %b want %b", fe.name, loadBusy, fe.busy);
      end
      if (loadReady !== fe.ready) begin
        fails++;
        $display("FAIL %s ready got %b want %b", fe.name, loadReady, fe.ready);
      end
      $display("fetch %-18s slot=%0d addr=%0d data=%h busy=%b ready=%b",
               fe.name, fetchSlot, address, iRAMOutput, loadBusy, loadReady);
    end
    if (loadDone === 1'b1 || loadError === 1'b1) begin
      asserts++;
      if (ev_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event done=%b error=%b want no event (cycle %0d)",
                 loadDone, loadError, cyc);
      end else begin
        ee = ev_q.pop_front();
        if (loadDone === loadError || loadDone !== ee.is_done || cyc != ee.cyc) begin
          fails++;
          $display("FAIL %s got done=%b error=%b at cycle %0d want %s at cycle %0d",
                   ee.name, loadDone, loadError, cyc, ee.is_done ? "done" : "error", ee.cyc);
        end else begin
          $display("event %-18s %s at cycle %0d", ee.name, ee.is_done ? "done" : "error", cyc);
        end
      end
    end
    if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      ee = ev_q.pop_front();
      asserts++;
      fails++;
      $display("FAIL %s got no event want %s at cycle %0d",
               ee.name, ee.is_done ? "done" : "error", ee.cyc);
    end
    if (tmo_seen != tmo_events) begin
      tmo_seen++;
      asserts++;
      fails++;
      $display("FAIL ready_timeout got loadReady=0 want 1 within 20 cycles");
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      asserts++;
      if (ev_q.size() != 0 || fetch_q.size() != 0) begin
        fails++;
        $display("FAIL pending_expectations got %0d events %0d fetches want 0 0",
                 ev_q.size(), fetch_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_chk(input string n, input logic [2:0] s, input logic [6:0] a,
                           input logic [31:0] d, input logic b, input logic r);
    fetch_exp_t e;
    fetchSlot = s;
    address   = a;
    e.name = n; e.data = d; e.busy = b; e.ready = r;
    fetch_q.push_back(e);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic expect_ev(input string n, input bit d);
    ev_exp_t e;
    e.name = n; e.is_done = d; e.cyc = cyc + 1;
    ev_q.push_back(e);
  endtask

  task automatic start(input string n, input logic [2:0] s, input logic [7:0] len, input bit bad);
    if (bad) expect_ev(n, 1'b0);
    loadStart  = 1'b1;
    loadSlot   = s;
    loadLength = len;
    tick();
    loadStart  = 1'b0;
  endtask

  // ev: 0 = none, 1 = accept ends the load with done, 2 = with error
  task automatic send(input string n, input logic [31:0] w, input int ev);
    loadValid = 1'b1;
    loadData  = w;
    for (int i = 0; i < 20 && loadReady !== 1'b1; i++) tick();
    if (loadReady !== 1'b1) tmo_events++;
    if (ev == 1) expect_ev(n, 1'b1);
    if (ev == 2) expect_ev(n, 1'b0);
    tick();
    loadValid = 1'b0;
  endtask

  task automatic load_tail(input string n, input logic [31:0] last, input logic [31:0] csum);
`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
    send(n, last, 0);
    send(n, csum, 1);
`else
    if (csum == 32'h0) $display("note: checksum operand unused");
    send(n, last, 1);
`endif
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    fetch_chk("reset_fetch", 3'd0, 7'd5, NOP, 1'b0, 1'b0);

    // load slot 2 with a one-cycle valid gap after the first word
    start("t2_start", 3'd2, 8'd3, 1'b0);
    send("t2_w0", 32'h11, 0);
    fetch_chk("t2_gap", 3'd2, 7'd0, NOP, 1'b1, 1'b1);
    send("t2_w1", 32'h22, 0);
    load_tail("t2_done", 32'h33, 32'hFFFFFF9A);
    fetch_chk("t2_done_cycle", 3'd2, 7'd1, NOP, 1'b1, 1'b0);
    fetch_chk("t2_slot2_a1", 3'd2, 7'd1, 32'h22, 1'b0, 1'b0);
    fetch_chk("t2_slot2_a2", 3'd2, 7'd2, 32'h33, 1'b0, 1'b0);
    fetch_chk("t2_slot3_a1", 3'd3, 7'd1, NOP, 1'b0, 1'b0);

    // rejected lengths
    start("t3_len0", 3'd3, 8'd0, 1'b1);
    fetch_chk("t3_len0_idle", 3'd3, 7'd0, NOP, 1'b0, 1'b0);
    start("t3_len129", 3'd4, 8'd129, 1'b1);
    fetch_chk("t3_len129_idle", 3'd4, 7'd0, NOP, 1'b0, 1'b0);
    fetch_chk("t3_slot2_kept", 3'd2, 7'd1, 32'h22, 1'b0, 1'b0);

    // reload the slot being executed
    start("t4_start", 3'd2, 8'd2, 1'b0);
    fetch_chk("t4_reload_nop", 3'd2, 7'd0, NOP, 1'b1, 1'b1);
    send("t4_w0", 32'hAA, 0);
    load_tail("t4_done", 32'hBB, 32'hFFFFFE9B);
    fetch_chk("t4_done_cycle", 3'd2, 7'd0, NOP, 1'b1, 1'b0);
    fetch_chk("t4_new_a0", 3'd2, 7'd0, 32'hAA, 1'b0, 1'b0);
    fetch_chk("t4_new_a1", 3'd2, 7'd1, 32'hBB, 1'b0, 1'b0);

    // reset in the middle of a 4-word load
    start("t5_start", 3'd5, 8'd4, 1'b0);
    send("t5_w0", 32'h1, 0);
    send("t5_w1", 32'h2, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fetch_chk("t5_slot2_nop", 3'd2, 7'd0, NOP, 1'b0, 1'b0);
    fetch_chk("t5_slot5_nop", 3'd5, 7'd0, NOP, 1'b0, 1'b0);
    start("t5_reload", 3'd1, 8'd1, 1'b0);
    load_tail("t5_done", 32'h77, 32'hFFFFFF89);
    tick();
    fetch_chk("t5_slot1_a0", 3'd1, 7'd0, 32'h77, 1'b0, 1'b0);

`ifdef INSTR_RAM_LOAD_CHECKSUM_EN
    start("t6_start", 3'd6, 8'd2, 1'b0);
    send("t6_w0", 32'h1, 0);
    send("t6_w1", 32'h2, 0);
    send("t6_csum_ok", 32'hFFFFFFFD, 1);
    tick();
    fetch_chk("t6_slot6_a1", 3'd6, 7'd1, 32'h2, 1'b0, 1'b0);
    start("t7_start", 3'd7, 8'd2, 1'b0);
    send("t7_w0", 32'h1, 0);
    send("t7_w1", 32'h2, 0);
    send("t7_csum_bad", 32'h0, 2);
    fetch_chk("t7_slot7_nop", 3'd7, 7'd0, NOP, 1'b0, 1'b0);
`endif

    repeat (3) tick();
    end_req = 1'b1;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/instruction_ram_slots.md
Name: instruction_ram_slots

Overview:
- Parametrised successor to the single-program instruction RAM.
- Memory is split into NUM_SLOTS equal program slots, so the OS layer can hold several resident programs. Examples are the BIOS in slot 0 and user programs in the other slots.
- Slots are filled at run time through a valid/ready load stream from the HD/serial loader, not by hard-coded initial contents.
- The fetch path serves the CPU with an asynchronous read relative to the selected slot. A slot that is not loaded returns NOP.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- SLOT_DEPTH, 128, words per slot; must be a power of two.
- NUM_SLOTS, 8, number of program slots; must be a power of two.
- NOP_WORD, 32'h6C000000, word returned from unloaded slots (the ISA Nop encoding).
- Derived: OFFS_W = log2(SLOT_DEPTH); SLOT_W = log2(NUM_SLOTS); total depth = SLOT_DEPTH*NUM_SLOTS (1024 by default).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetchSlot  in  SLOT_W  slot the CPU executes from.
- address  in  OFFS_W  PC offset within fetchSlot.
- iRAMOutput  out  DATA_WIDTH  fetched instruction (combinational).
- loadStart  in  1  request a load; sampled in IDLE only.
- loadSlot  in  SLOT_W  destination slot; captured on accepted loadStart.
- loadLength  in  OFFS_W+1  word count; captured on accepted loadStart.
- loadValid  in  1  loadData is valid.
- loadData  in  DATA_WIDTH  program word.
- loadReady  out  1  block accepts a word this cycle.
- loadBusy  out  1  FSM is not IDLE.
- loadDone  out  1  one-cycle pulse: slot loaded successfully.
- loadError  out  1  one-cycle pulse: load rejected or failed.

Behaviour:
- Reset values:
  - State is IDLE and the word counter is 0.
  - All slotValid bits are 0.
  - loadReady, loadBusy, loadDone and loadError are 0.
  - Memory contents are not cleared.
- Fetch path:
  - If slotValid[fetchSlot] is 1, iRAMOutput = mem[{fetchSlot, address}].
  - Otherwise iRAMOutput = NOP_WORD.
  - Zero latency (combinational read). There is no fetch-side handshake.
- State IDLE:
  - When loadStart=1:
    - loadLength==0 or loadLength>SLOT_DEPTH: loadError pulses next cycle and the FSM stays IDLE.
    - Otherwise: capture slot and length, clear slotValid[loadSlot] on that same edge, counter=0, go to LOAD.
- State LOAD:
  - loadReady=1 and loadBusy=1.
  - A word is accepted when loadValid&&loadReady. On acceptance, mem[{slot,counter}]<=loadData and counter increments.
  - Gaps in loadValid are allowed and stall the counter.
  - The accept with counter==length-1 moves the FSM to DONE (or CHECK when LOAD_CHECKSUM_EN is defined).
  - loadStart is ignored.
- State DONE (1 cycle):
  - loadDone=1, slotValid[slot]<=1, loadReady=0, then IDLE.
  - The fetch from that slot sees the new contents from the cycle after DONE.
- Reload of the slot currently executing: it reads NOP_WORD from the cycle after loadStart is accepted until DONE completes.
- Fetch and load to the same address in the same cycle: fetch returns NOP_WORD, because the slot is invalid.
- Reset mid-load: the FSM returns to IDLE and all slots become invalid. No loadDone or loadError is produced.
- Address arithmetic: the physical address is the concatenation {slot, offset}. No wrap-around is possible because both fields are exact widths.

Optional Feature:
- Macro: INSTR_RAM_LOAD_CHECKSUM_EN.
- Defined:
  - After the last program word, the FSM enters CHECK with loadReady=1 and accepts one extra checksum word. This word is not written to memory.
  - A running sum (mod 2^DATA_WIDTH) of the program words is kept.
  - sum + checksum == 0: go to DONE.
  - Otherwise: loadError pulses, the slot stays invalid, and the FSM returns to IDLE.
- Undefined: no CHECK state and no accumulator; the FSM goes directly from LOAD to DONE.

Decomposition:
- Shared package instr_mem_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, DONE);
  - the NOP_WORD constant;
  - default DATA_WIDTH, SLOT_DEPTH and NUM_SLOTS constants.
- One sub-module, instr_load_fsm, owns:
  - the handshake, counter, checksum, and slotValid set/clear strobes.
- It emits write enable, write address and write data to the top-level memory array.

Test Plan:
- Reset, then fetch slot 0 address 5 -> iRAMOutput=32'h6C000000, loadBusy=0.
- loadStart slot 2, length 3; words 32'h11,22,33 with a one-cycle loadValid gap after the first word -> loadDone pulses one cycle after the third accept. Then fetch slot 2 address 1 -> 32'h22, and fetch slot 3 address 1 -> NOP.
- loadStart with length 0, and separately with length 129 -> loadError pulses once each, loadBusy stays 0, and no slot changes.
- With slot 2 loaded and fetchSlot=2, issue loadStart slot 2 -> fetch returns NOP from the next cycle until the new loadDone, then returns the new contents.
- Assert reset after 2 of 4 words -> next cycle IDLE, all slots NOP, and a subsequent load of 1 word succeeds.
- With INSTR_RAM_LOAD_CHECKSUM_EN defined, load words 1,2 and then checksum 32'hFFFFFFFD -> loadDone. The same load with checksum 0 -> loadError and the slot reads NOP.
